sub_45bit_seq: RTL

Multi-cycle 45-bit subtractor computing D = A - B - bin. It walks the borrow chain CHUNK bits per clock, so long-word subtract costs little area and has a short critical path. It is the inverse-operation companion to the team's ripple-carry adder, with the same operand width and bit indexing. Valid/ready handshakes on both sides let it sit directly in the arithmetic datapath between operand staging and result writeback.

---
 rtl/sub_45bit_seq_if.sv | 36 +++
 rtl/sub_45bit_seq.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/sub_45bit_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : sub_45bit_seq_if
// Description : Operand/result handshake bundle for the sequential
//               subtractor. The master side presents operands and accepts
//               results; the slave side is the subtractor itself.
//   in_valid/in_ready   : operand handshake (A, B, bin)
//   out_valid/out_ready : result handshake (D, bout, zero)
//   Vectors are indexed [WIDTH:1], bit 1 = LSB.
// Revision    : 1.0 - initial release
// ============================================================================
interface sub_45bit_seq_if #(
    parameter int WIDTH = 45
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:1]   A;
    logic [WIDTH:1]   B;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:1]   D;
    logic             bout;
    logic             zero;

    modport master (
        output in_valid, A, B, bin, out_ready,
        input  in_ready, out_valid, D, bout, zero
    );

    modport slave (
        input  in_valid, A, B, bin, out_ready,
        output in_ready, out_valid, D, bout, zero
    );
endinterface
`default_nettype wire

// File: rtl/sub_45bit_seq.sv
`default_nettype none
// ============================================================================
// Module      : sub_45bit_seq
// Description : Multi-cycle subtractor, D = A - B - bin (mod 2^WIDTH).
//               The borrow chain is resolved CHUNK bits per clock, taking
//               N = ceil(WIDTH/CHUNK) compute cycles per operation.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : slave side of sub_45bit_seq_if (operand and result handshakes)
//            D     - difference [WIDTH:1]
//            bout  - 1 iff A < B + bin (unsigned)
//            zero  - 1 iff D == 0
// Revision    : 1.0 - initial release
// ============================================================================
module sub_45bit_seq #(
    parameter int WIDTH = 45,
    parameter int CHUNK = 9
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    sub_45bit_seq_if.slave bus
);

    localparam int N     = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int PW    = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [WIDTH:1]     a_q;
    logic [WIDTH:1]     b_q;
    logic [WIDTH:1]     d_q;
    logic               br_q;
    logic               bout_q;
    logic               zero_q;
    logic [IDX_W-1:0]   idx_q;

    logic [WIDTH:1]     d_chunk;
    logic               br_chunk;
    logic               last_chunk;

    // Resolve the chunk selected by idx_q. Bits outside that chunk keep their
    // D value and pass the borrow through untouched, so the borrow seen at
    // the end of the walk is the one leaving the active chunk. A partial last
    // chunk simply has fewer active bits; nothing above WIDTH exists.
    always_comb begin
        logic          br;
        logic [PW-1:0] bit_i;
        d_chunk = d_q;
        br      = br_q;
        bit_i   = '0;
        for (int p = 1; p <= WIDTH; p++) begin
            bit_i = PW'(p);
            if (idx_q == IDX_W'((p - 1) / CHUNK)) begin
                d_chunk[bit_i] = a_q[bit_i] ^ b_q[bit_i] ^ br;
                br = (~a_q[bit_i] & b_q[bit_i]) |
                     (~(a_q[bit_i] ^ b_q[bit_i]) & br);
            end
        end
        br_chunk = br;
    end

    assign last_chunk = (idx_q == IDX_W'(N - 1));

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            d_q    <= '0;
            br_q   <= 1'b0;
            bout_q <= 1'b0;
            zero_q <= 1'b0;
            idx_q  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.A;
                        b_q   <= bus.B;
                        br_q  <= bus.bin;
                        idx_q <= '0;
                    end
                end
                BUSY: begin
                    d_q   <= d_chunk;
                    br_q  <= br_chunk;
                    idx_q <= idx_q + IDX_W'(1);
                    if (last_chunk) begin
                        bout_q <= br_chunk;
                        zero_q <= (d_chunk == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_chunk) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.D    = d_q;
    assign bus.bout = bout_q;
    assign bus.zero = zero_q;

endmodule
`default_nettype wire
